// File: rtl/call_return_unit.sv
// ---------------------------------------------------------------------------
// call_return_unit
//
// Subroutine-linkage controller and sole master of a byte-wide hardware
// stack. A CALL saves a 16-bit return address as two pushes (low byte
// first, high byte last). A RET pops the two bytes back (high byte first)
// and presents the reassembled address on ret_addr. Occupancy is tracked
// in bytes. A transfer that would overflow or underflow the stack is
// refused with a one-cycle error pulse and causes no stack activity.
//
// Handshake: call_req / ret_req are level requests. They are sampled only
// while busy=0. call_req wins over ret_req. A request seen while busy=1 is
// dropped, not queued. Completion is signalled by a one-cycle pulse:
// call_done, ret_valid, err_overflow or err_underflow.
//
// Ports
//   clk            system clock, rising-edge active
//   Reset_n        asynchronous active-low reset (shared with the stack)
//   call_req       push pc_in (sampled in IDLE only)
//   ret_req        pop a return address (sampled in IDLE only)
//   pc_in[15:0]    return address, latched when a CALL is accepted
//   stack_dout[7:0] stack read data, valid the cycle after stack_read
//   stack_read     pop strobe to the stack
//   stack_write    push strobe to the stack
//   stack_din[7:0] push data, 8'h00 whenever stack_write=0
//   busy           transfer in progress (state != IDLE)
//   call_done      pulse: both CALL bytes pushed
//   ret_valid      pulse: ret_addr holds a freshly popped address
//   ret_addr[15:0] last popped address, held until the next good RET
//   err_overflow   pulse: CALL refused, stack full
//   err_underflow  pulse: RET refused, stack empty
//   depth[7:0]     current occupancy in bytes
//   state_dbg[2:0] current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module call_return_unit #(
    parameter int unsigned DEPTH_BYTES = 255
) (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic        call_req,
    input  logic        ret_req,
    input  logic [15:0] pc_in,
    input  logic [7:0]  stack_dout,
    output logic        stack_read,
    output logic        stack_write,
    output logic [7:0]  stack_din,
    output logic        busy,
    output logic        call_done,
    output logic        ret_valid,
    output logic [15:0] ret_addr,
    output logic        err_overflow,
    output logic        err_underflow,
    output logic [7:0]  depth,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUSH_LO = 3'd1,
        PUSH_HI = 3'd2,
        POP_HI  = 3'd3,
        POP_LO  = 3'd4,
        POP_CAP = 3'd5
    } state_t;

    // Highest occupancy at which a two-byte CALL still fits.
    localparam logic [7:0] CALL_LIMIT = 8'(DEPTH_BYTES - 2);
    localparam logic [7:0] RET_MIN    = 8'd2;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc_lat;
    logic [7:0]  hi_byte;

    logic        call_done_next;
    logic        ret_valid_next;
    logic        err_ovf_next;
    logic        err_unf_next;
    logic        latch_pc;

    // -----------------------------------------------------------------------
    // Next-state and pulse decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        call_done_next = 1'b0;
        ret_valid_next = 1'b0;
        err_ovf_next   = 1'b0;
        err_unf_next   = 1'b0;
        latch_pc       = 1'b0;

        case (state)
            IDLE: begin
                if (call_req) begin
                    // ret_req is dropped silently when both are raised.
                    if (depth <= CALL_LIMIT) begin
                        state_next = PUSH_LO;
                        latch_pc   = 1'b1;
                    end else begin
                        err_ovf_next = 1'b1;
                    end
                end else if (ret_req) begin
                    if (depth >= RET_MIN) begin
                        state_next = POP_HI;
                    end else begin
                        err_unf_next = 1'b1;
                    end
                end
            end
            PUSH_LO: state_next = PUSH_HI;
            PUSH_HI: begin
                state_next     = IDLE;
                call_done_next = 1'b1;
            end
            POP_HI:  state_next = POP_LO;
            POP_LO:  state_next = POP_CAP;
            POP_CAP: begin
                state_next     = IDLE;
                ret_valid_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath: latched PC, popped bytes, occupancy and completion pulses
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_lat        <= 16'h0000;
            hi_byte       <= 8'h00;
            ret_addr      <= 16'h0000;
            depth         <= 8'd0;
            call_done     <= 1'b0;
            ret_valid     <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            call_done     <= call_done_next;
            ret_valid     <= ret_valid_next;
            err_overflow  <= err_ovf_next;
            err_underflow <= err_unf_next;

            if (latch_pc) begin
                pc_lat <= pc_in;
            end

            case (state)
                PUSH_LO, PUSH_HI: depth <= depth + 8'd1;
                POP_HI:           depth <= depth - 8'd1;
                POP_LO: begin
                    depth   <= depth - 8'd1;
                    // Data for the POP_HI read arrives during POP_LO.
                    hi_byte <= stack_dout;
                end
                POP_CAP: begin
                    // Data for the POP_LO read arrives during POP_CAP.
                    ret_addr <= {hi_byte, stack_dout};
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Stack strobes are pure state decodes, so they drop to 0 the instant
    // reset is asserted.
    // -----------------------------------------------------------------------
    always_comb begin
        stack_write = 1'b0;
        stack_read  = 1'b0;
        stack_din   = 8'h00;
        case (state)
            PUSH_LO: begin
                stack_write = 1'b1;
                stack_din   = pc_lat[7:0];
            end
            PUSH_HI: begin
                stack_write = 1'b1;
                stack_din   = pc_lat[15:8];
            end
            POP_HI, POP_LO: stack_read = 1'b1;
            default: ;
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_call_return_unit.sv
module tb_call_return_unit;

    localparam int DB = 6;
    localparam int W  = 28;   // {kind[3:0], ret_addr[15:0], depth[7:0]}

    logic        clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        call_req = 1'b0;
    logic        ret_req = 1'b0;
    logic [15:0] pc_in = 16'h0000;
    logic [7:0]  stack_dout;
    logic        stack_read, stack_write, busy, call_done, ret_valid;
    logic        err_overflow, err_underflow;
    logic [7:0]  stack_din, depth;
    logic [15:0] ret_addr;
    logic [2:0]  state_dbg;

    call_return_unit #(.DEPTH_BYTES(DB)) dut (
        .clk(clk), .Reset_n(Reset_n), .call_req(call_req), .ret_req(ret_req),
        .pc_in(pc_in), .stack_dout(stack_dout), .stack_read(stack_read),
        .stack_write(stack_write), .stack_din(stack_din), .busy(busy),
        .call_done(call_done), .ret_valid(ret_valid), .ret_addr(ret_addr),
        .err_overflow(err_overflow), .err_underflow(err_underflow),
        .depth(depth), .state_dbg(state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- byte-wide stack environment ----------------
    logic [7:0] mem [0:255];
    int sp = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    always @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sp         <= 0;
            stack_dout <= 8'h00;
        end else if (stack_write) begin
            mem[sp] <= stack_din;
            sp      <= sp + 1;
            wr_cnt  <= wr_cnt + 1;
        end else if (stack_read) begin
            if (sp > 0) begin
                stack_dout <= mem[sp-1];
                sp         <= sp - 1;
            end
            rd_cnt <= rd_cnt + 1;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [15:0]  m_stack[$];      // saved return addresses, one per CALL
    logic [15:0]  m_ret = 16'h0000;
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    int tests = 0;
    int fails = 0;

    function automatic int m_depth();
        return m_stack.size() * 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] kind, input int when);
        exp_q.push_back({kind, m_ret, 8'(m_depth())});
        exp_cyc_q.push_back(when);
    endtask

    // Monitor: pops one expectation for every completion/error pulse.
    always @(negedge clk) begin
        if (Reset_n) begin
            if (stack_read && stack_write) check("strobe_exclusive", 1, 0);
            if (!stack_write && stack_din !== 8'h00) check("din_zero", {24'd0, stack_din}, 0);
            if (call_done || ret_valid || err_overflow || err_underflow) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event actual=%b%b%b%b required=none (t=%0t)",
                             call_done, ret_valid, err_overflow, err_underflow, $time);
                end else begin
                    logic [W-1:0] e;
                    int c;
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    check("event", {4'd0, call_done, ret_valid, err_overflow, err_underflow, ret_addr, depth}, {4'd0, e});
                    check("latency", cyc, c);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    // Issues one request in cycle T; returns #1 into T+1.
    task automatic issue(input bit c, input bit r, input logic [15:0] pc);
        int t;
        wait_idle();
        call_req = c;
        ret_req  = r;
        pc_in    = pc;
        t = cyc;
        if (c) begin
            if (m_depth() <= DB - 2) begin
                m_stack.push_back(pc);
                push_exp(4'b1000, t + 3);
            end else begin
                push_exp(4'b0010, t + 1);
            end
        end else if (r) begin
            if (m_depth() >= 2) begin
                m_ret = m_stack.pop_back();
                push_exp(4'b0100, t + 4);
            end else begin
                push_exp(4'b0001, t + 1);
            end
        end
        @(posedge clk);
        #1;
        call_req = 1'b0;
        ret_req  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w0, r0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, busy}, 0);
        check("rst_write", {31'd0, stack_write}, 0);
        check("rst_read",  {31'd0, stack_read}, 0);
        Reset_n = 1'b1;
        @(negedge clk);
        check("rst_depth", {24'd0, depth}, 0);
        check("rst_ret_addr", {16'd0, ret_addr}, 0);
        check("rst_state", {29'd0, state_dbg}, 0);

        // CALL A5C3: byte order and timing
        issue(1, 0, 16'hA5C3);
        check("push_lo_we",  {31'd0, stack_write}, 1);
        check("push_lo_din", {24'd0, stack_din}, 32'hC3);
        check("call_busy1",  {31'd0, busy}, 1);
        @(posedge clk); #1;
        check("push_hi_we",  {31'd0, stack_write}, 1);
        check("push_hi_din", {24'd0, stack_din}, 32'hA5);
        @(posedge clk); #1;
        check("call_done_t3", {31'd0, call_done}, 1);
        check("call_idle_t3", {31'd0, busy}, 0);
        check("call_depth",   {24'd0, depth}, 2);
        issue(0, 1, 16'h0);   // pop A5C3 back
        drain();
        check("ret_a5c3", {16'd0, ret_addr}, 32'hA5C3);

        // Nested CALL/CALL/RET/RET
        issue(1, 0, 16'h1234);
        issue(1, 0, 16'hBEEF);
        issue(0, 1, 16'h0);
        issue(0, 1, 16'h0);
        drain();
        check("nested_ret", {16'd0, ret_addr}, 32'h1234);
        check("nested_depth", {24'd0, depth}, 0);

        // RET at depth 0
        r0 = rd_cnt;
        issue(0, 1, 16'h0);
        check("unf_busy", {31'd0, busy}, 0);
        check("unf_pulse", {31'd0, err_underflow}, 1);
        drain();
        check("unf_no_read", rd_cnt - r0, 0);
        check("unf_ret_addr", {16'd0, ret_addr}, 32'h1234);

        // Fill to DB and overflow
        issue(1, 0, 16'h1111);
        issue(1, 0, 16'h2222);
        issue(1, 0, 16'h3333);
        drain();
        w0 = wr_cnt;
        issue(1, 0, 16'h4444);
        check("ovf_pulse", {31'd0, err_overflow}, 1);
        drain();
        check("ovf_no_write", wr_cnt - w0, 0);
        check("ovf_depth", {24'd0, depth}, DB);

        // Both requests at depth 2; ret_req raised while busy is ignored
        issue(0, 1, 16'h0);
        issue(0, 1, 16'h0);
        drain();
        issue(1, 1, 16'h5A5A);
        ret_req = 1'b1;
        @(posedge clk); #1;
        ret_req = 1'b0;
        drain();
        repeat (6) @(negedge clk);
        check("both_depth", {24'd0, depth}, 4);

        // Randomised traffic
        for (int i = 0; i < 150; i++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k < 5)      issue(1, 0, 16'($urandom));
            else if (k < 9) issue(0, 1, 16'h0);
            else            issue(1, 1, 16'($urandom));
        end
        drain();
        while (m_stack.size() != 0) issue(0, 1, 16'h0);
        drain();

        // Reset during PUSH_HI
        issue(1, 0, 16'hCAFE);
        @(posedge clk); #1;
        check("pre_rst_state", {29'd0, state_dbg}, 2);
        Reset_n = 1'b0;
        #1;
        check("arst_write", {31'd0, stack_write}, 0);
        check("arst_din",   {24'd0, stack_din}, 0);
        check("arst_busy",  {31'd0, busy}, 0);
        check("arst_depth", {24'd0, depth}, 0);
        void'(exp_q.pop_back());
        void'(exp_cyc_q.pop_back());
        m_stack.delete();
        m_ret = 16'h0000;
        @(negedge clk);
        Reset_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(0, 1, 16'h0);
        check("post_rst_unf", {31'd0, err_underflow}, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/call_return_unit.md
# call_return_unit

Subroutine-linkage controller that sits directly upstream of the byte-wide hardware stack and is its only master. On CALL it pushes a 16-bit return address as two bytes (low byte first, high byte last); on RET it pops both bytes and presents the reassembled address to the program counter. It tracks stack occupancy in bytes and refuses, with an error pulse, any transfer that would overflow or underflow the stack.

## Interface
- DEPTH_BYTES, default 255: usable stack capacity in bytes. Must be ≥2.
- clk  in  1  system clock; all state changes on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset. Must be driven together with the stack's own reset.
- call_req  in  1  request to push pc_in. Sampled only in IDLE.
- ret_req  in  1  request to pop a return address. Sampled only in IDLE.
- pc_in  in  16  return address to save. Latched on CALL acceptance.
- stack_dout  in  8  stack read data. Valid the cycle after stack_read is asserted.
- stack_read  out  1  pop strobe to the stack.
- stack_write  out  1  push strobe to the stack.
- stack_din  out  8  push data to the stack.
- busy  out  1  high while a transfer is in progress (state ≠ IDLE).
- call_done  out  1  one-cycle pulse when both CALL bytes have been pushed.
- ret_valid  out  1  one-cycle pulse when ret_addr holds a new popped address.
- ret_addr  out  16  last popped return address. Held until the next successful RET.
- err_overflow  out  1  one-cycle pulse: CALL rejected because the stack is full.
- err_underflow  out  1  one-cycle pulse: RET rejected because the stack is empty.
- depth  out  8  current occupancy in bytes, 0..DEPTH_BYTES.

## Operation
- States:
  - IDLE
  - PUSH_LO, PUSH_HI (CALL path)
  - POP_HI, POP_LO, POP_CAP (RET path)
- IDLE behaviour:
  - call_req has priority over ret_req. If both are asserted, CALL is evaluated and ret_req is dropped without an error.
  - CALL is accepted when depth ≤ DEPTH_BYTES−2. Otherwise err_overflow pulses and there is no stack activity.
  - RET is accepted when depth ≥ 2. Otherwise err_underflow pulses and there is no stack activity.
- PUSH_LO: stack_write=1, stack_din=pc_lat[7:0], depth+1. Next state PUSH_HI.
- PUSH_HI: stack_write=1, stack_din=pc_lat[15:8], depth+1. Next state IDLE, with call_done pulsing in the first IDLE cycle.
- POP_HI: stack_read=1, depth−1. Next state POP_LO.
- POP_LO: stack_read=1, depth−1. The high byte is captured from stack_dout at the end of this cycle. Next state POP_CAP.
- POP_CAP: the low byte is captured from stack_dout. ret_addr={hi,lo} is updated at the end of this cycle. Next state IDLE, with ret_valid pulsing in the first IDLE cycle.
- stack_read and stack_write are never asserted together. Both are 0 in IDLE and POP_CAP.
- stack_din is 8'h00 whenever stack_write=0.
- Requests arriving while busy=1 are ignored, not queued.
- Depth arithmetic: 8-bit unsigned. The accept checks guarantee it never wraps below 0 or above DEPTH_BYTES.

## Timing
- Reset (Reset_n low, asynchronous):
  - state=IDLE, depth=0, ret_addr=16'h0000.
  - All strobes, pulses, busy and stack_din are 0.
  - Reset asserted mid-transfer aborts the transfer immediately. There is no partial call_done or ret_valid, and depth returns to 0. The stack is reset simultaneously, so the two stay consistent.
- CALL accepted in cycle T:
  - busy=1 in T+1..T+2.
  - stack_write in T+1 (low byte) and T+2 (high byte).
  - call_done=1 and busy=0 in T+3.
  - A new request may be accepted in T+3.
- RET accepted in cycle T:
  - stack_read in T+1..T+2; busy=1 in T+1..T+3.
  - ret_valid=1 with the new ret_addr in T+4. A new request may be accepted in T+4.
- Rejection in cycle T: the error pulse appears in T+1 and busy stays 0.
- Throughput:
  - One CALL every 3 cycles and one RET every 4 cycles when requests are held high.
  - Back-to-back CALL then RET returns the same address.

## Test plan
- Reset then CALL pc_in=16'hA5C3:
  - stack_din=8'hC3 at T+1 and 8'h A5 at T+2.
  - call_done at T+3; depth=2.
- CALL 16'h1234, CALL 16'hBEEF, RET, RET:
  - ret_addr=16'hBEEF, then 16'h1234.
  - Each ret_valid arrives 4 cycles after its acceptance; depth returns to 0.
- RET at depth=0:
  - err_underflow pulses at T+1.
  - No stack_read, busy stays 0, ret_addr unchanged.
- Fill with DEPTH_BYTES=6 (3 CALLs, depth=6), then a 4th CALL:
  - err_overflow pulses.
  - No stack_write; depth stays 6.
- call_req and ret_req both high at depth=2:
  - CALL executes, depth=4.
  - No underflow or overflow error; a request raised while busy is ignored.
- Reset_n low during PUSH_HI of a CALL:
  - All outputs are 0 asynchronously, depth=0, and no call_done.
  - A subsequent RET gives err_underflow.
